// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU op codes (csig), MIPS
// opcode/funct constants, operand-B select codes and the issue FSM states.
package alu_pkg;

    // csig encoding understood by the ALU.
    typedef enum logic [3:0] {
        OP_OR   = 4'b0000,
        OP_AND  = 4'b0001,
        OP_XOR  = 4'b0010,
        OP_SLL  = 4'b0011,
        OP_SRL  = 4'b0100,
        OP_SUB  = 4'b0101,
        OP_ADD  = 4'b0110,
        OP_NOR  = 4'b0111,
        OP_NAND = 4'b1000,
        OP_SLT  = 4'b1001,
        OP_MUL  = 4'b1010,
        OP_CLR  = 4'b1011,
        OP_STF  = 4'b1100,
        OP_LWSW = 4'b1101,
        OP_SRA  = 4'b1110,
        OP_ANDN = 4'b1111
    } alu_op_e;

    // Primary opcodes, instruction[31:26].
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    // R-type function codes, instruction[5:0].
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_MUL = 6'h18;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Operand B source.
    localparam logic [1:0] BSEL_RT    = 2'd0;
    localparam logic [1:0] BSEL_SHAMT = 2'd1;
    localparam logic [1:0] BSEL_IMM   = 2'd2;
    localparam logic [1:0] BSEL_ZERO  = 2'd3;

    // Write-back destination source.
    localparam logic WDEST_RD = 1'b0;
    localparam logic WDEST_RT = 1'b1;

    // Issue buffer occupancy.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } issue_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational MIPS opcode/funct decoder producing the ALU op code and the
// operand/destination selects used by the issue stage.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] csig,
    output logic [1:0] b_sel,
    output logic       imm_ext,
    output logic       wdest_sel,
    output logic       wen,
    output logic       illegal
);

    // Map opcode/funct to op code and selects; anything unknown becomes CLR.
    always_comb begin
        csig      = OP_CLR;
        b_sel     = BSEL_ZERO;
        imm_ext   = 1'b0;
        wdest_sel = WDEST_RD;
        wen       = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                wdest_sel = WDEST_RD;
                wen       = 1'b1;
                b_sel     = BSEL_RT;
                case (funct)
                    FN_OR:  csig = OP_OR;
                    FN_AND: csig = OP_AND;
                    FN_XOR: csig = OP_XOR;
                    FN_NOR: csig = OP_NOR;
                    FN_SUB: csig = OP_SUB;
                    FN_ADD: csig = OP_ADD;
                    FN_SLT: csig = OP_SLT;
                    FN_MUL: csig = OP_MUL;
                    FN_SLL: begin csig = OP_SLL; b_sel = BSEL_SHAMT; end
                    FN_SRL: begin csig = OP_SRL; b_sel = BSEL_SHAMT; end
                    FN_SRA: begin csig = OP_SRA; b_sel = BSEL_SHAMT; end
                    default: begin
                        csig    = OP_CLR;
                        b_sel   = BSEL_ZERO;
                        wen     = 1'b0;
                        illegal = 1'b1;
                    end
                endcase
            end
            OPC_ADDI: begin csig = OP_ADD;  b_sel = BSEL_IMM; imm_ext = 1'b1; wdest_sel = WDEST_RT; wen = 1'b1; end
            OPC_SLTI: begin csig = OP_SLT;  b_sel = BSEL_IMM; imm_ext = 1'b1; wdest_sel = WDEST_RT; wen = 1'b1; end
            OPC_ANDI: begin csig = OP_AND;  b_sel = BSEL_IMM; imm_ext = 1'b0; wdest_sel = WDEST_RT; wen = 1'b1; end
            OPC_ORI:  begin csig = OP_OR;   b_sel = BSEL_IMM; imm_ext = 1'b0; wdest_sel = WDEST_RT; wen = 1'b1; end
            OPC_XORI: begin csig = OP_XOR;  b_sel = BSEL_IMM; imm_ext = 1'b0; wdest_sel = WDEST_RT; wen = 1'b1; end
            OPC_LW:   begin csig = OP_LWSW; b_sel = BSEL_IMM; imm_ext = 1'b1; wdest_sel = WDEST_RT; wen = 1'b1; end
            OPC_SW:   begin csig = OP_LWSW; b_sel = BSEL_IMM; imm_ext = 1'b1; wdest_sel = WDEST_RT; wen = 1'b0; end
            default: begin
                csig    = OP_CLR;
                b_sel   = BSEL_ZERO;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the ALU: decodes instruction fields into operands
// a/b plus csig and holds them in a 2-entry (output + skid) buffer behind a
// valid/ready handshake. Optional operand forwarding is enabled by the
// ALU_ISSUE_FWD_EN macro.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [5:0]    opcode,
    input  logic [5:0]    funct,
    input  logic [4:0]    shamt,
    input  logic [15:0]   imm16,
    input  logic [RW-1:0] rs_idx,
    input  logic [RW-1:0] rt_idx,
    input  logic [RW-1:0] rd_idx,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] rt_data,
    input  logic          flush,
    input  logic          out_ready,
`ifdef ALU_ISSUE_FWD_EN
    input  logic          fwd_valid,
    input  logic [RW-1:0] fwd_idx,
    input  logic [DW-1:0] fwd_data,
`endif
    output logic          out_valid,
    output logic [DW-1:0] a,
    output logic [DW-1:0] b,
    output logic [3:0]    csig,
    output logic [RW-1:0] wdest,
    output logic          wen,
    output logic          illegal
);

    logic [DW-1:0] rs_eff;
    logic [DW-1:0] rt_eff;

`ifdef ALU_ISSUE_FWD_EN
    // Late result bypass; register 0 is hard-wired and never forwarded.
    assign rs_eff = (fwd_valid && (fwd_idx == rs_idx) && (fwd_idx != '0)) ? fwd_data : rs_data;
    assign rt_eff = (fwd_valid && (fwd_idx == rt_idx) && (fwd_idx != '0)) ? fwd_data : rt_data;
`else
    assign rs_eff = rs_data;
    assign rt_eff = rt_data;
    // Source indices only matter for forwarding.
    logic unused_idx;
    assign unused_idx = ^{rs_idx, rt_idx};
`endif

    logic [3:0] dec_csig;
    logic [1:0] dec_b_sel;
    logic       dec_imm_ext;
    logic       dec_wdest_sel;
    logic       dec_wen;
    logic       dec_illegal;

    alu_op_decode u_decode (
        .opcode    (opcode),
        .funct     (funct),
        .csig      (dec_csig),
        .b_sel     (dec_b_sel),
        .imm_ext   (dec_imm_ext),
        .wdest_sel (dec_wdest_sel),
        .wen       (dec_wen),
        .illegal   (dec_illegal)
    );

    logic [DW-1:0] dec_a;
    logic [DW-1:0] dec_b;
    logic [RW-1:0] dec_wdest;

    // Build the candidate entry: shifts take rt as operand A, illegal ops zero both.
    always_comb begin
        dec_a = '0;
        dec_b = '0;
        if (!dec_illegal) begin
            dec_a = (dec_b_sel == BSEL_SHAMT) ? rt_eff : rs_eff;
        end
        case (dec_b_sel)
            BSEL_RT:    dec_b = rt_eff;
            BSEL_SHAMT: dec_b = {{(DW-5){1'b0}}, shamt};
            BSEL_IMM:   dec_b = dec_imm_ext ? {{(DW-16){imm16[15]}}, imm16}
                                            : {{(DW-16){1'b0}}, imm16};
            default:    dec_b = '0;
        endcase
        dec_wdest = (dec_wdest_sel == WDEST_RT) ? rt_idx : rd_idx;
    end

    issue_state_e  state_reg;
    issue_state_e  state_next;
    logic          in_ready_reg;

    logic [DW-1:0] a_reg, b_reg;
    logic [3:0]    csig_reg;
    logic [RW-1:0] wdest_reg;
    logic          wen_reg, illegal_reg;

    logic [DW-1:0] skid_a_reg, skid_b_reg;
    logic [3:0]    skid_csig_reg;
    logic [RW-1:0] skid_wdest_reg;
    logic          skid_wen_reg, skid_illegal_reg;

    logic accept;
    logic load_dec;
    logic load_from_skid;
    logic load_skid;

    assign accept = in_valid && in_ready_reg;

    // Occupancy FSM; flush wins over any simultaneous accept or drain.
    always_comb begin
        state_next     = state_reg;
        load_dec       = 1'b0;
        load_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (accept) begin
                    state_next = FULL;
                    load_dec   = 1'b1;
                end
            end
            FULL: begin
                if (accept && out_ready) begin
                    load_dec = 1'b1;
                end else if (accept) begin
                    state_next = SKID;
                    load_skid  = 1'b1;
                end else if (out_ready) begin
                    state_next = EMPTY;
                end
            end
            SKID: begin
                if (out_ready) begin
                    state_next     = FULL;
                    load_from_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        if (flush) begin
            state_next     = EMPTY;
            load_dec       = 1'b0;
            load_from_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // State, registered ready, output register and skid register updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= EMPTY;
            in_ready_reg     <= 1'b1;
            a_reg            <= '0;
            b_reg            <= '0;
            csig_reg         <= OP_CLR;
            wdest_reg        <= '0;
            wen_reg          <= 1'b0;
            illegal_reg      <= 1'b0;
            skid_a_reg       <= '0;
            skid_b_reg       <= '0;
            skid_csig_reg    <= OP_CLR;
            skid_wdest_reg   <= '0;
            skid_wen_reg     <= 1'b0;
            skid_illegal_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next != SKID);
            if (load_dec) begin
                a_reg       <= dec_a;
                b_reg       <= dec_b;
                csig_reg    <= dec_csig;
                wdest_reg   <= dec_wdest;
                wen_reg     <= dec_wen;
                illegal_reg <= dec_illegal;
            end else if (load_from_skid) begin
                a_reg       <= skid_a_reg;
                b_reg       <= skid_b_reg;
                csig_reg    <= skid_csig_reg;
                wdest_reg   <= skid_wdest_reg;
                wen_reg     <= skid_wen_reg;
                illegal_reg <= skid_illegal_reg;
            end
            if (flush) begin
                illegal_reg <= 1'b0;
            end
            if (load_skid) begin
                skid_a_reg       <= dec_a;
                skid_b_reg       <= dec_b;
                skid_csig_reg    <= dec_csig;
                skid_wdest_reg   <= dec_wdest;
                skid_wen_reg     <= dec_wen;
                skid_illegal_reg <= dec_illegal;
            end
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = (state_reg != EMPTY);
    assign a         = a_reg;
    assign b         = b_reg;
    assign csig      = csig_reg;
    assign wdest     = wdest_reg;
    assign wen       = wen_reg;
    assign illegal   = illegal_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage: reset, decode, back-pressure,
// flush and (with ALU_ISSUE_FWD_EN) forwarding.
module tb_alu_issue_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic [4:0]    shamt;
    logic [15:0]   imm16;
    logic [RW-1:0] rs_idx, rt_idx, rd_idx;
    logic [DW-1:0] rs_data, rt_data;
    logic          flush;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] a, b;
    logic [3:0]    csig;
    logic [RW-1:0] wdest;
    logic          wen;
    logic          illegal;
`ifdef ALU_ISSUE_FWD_EN
    logic          fwd_valid;
    logic [RW-1:0] fwd_idx;
    logic [DW-1:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    // {out_valid, a, b, csig, wdest, wen, illegal}
    logic [75:0] snap;
    logic [75:0] exp_snap;
    assign snap = {out_valid, a, b, csig, wdest, wen, illegal};

    alu_issue_stage #(.DW(DW), .RW(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .funct     (funct),
        .shamt     (shamt),
        .imm16     (imm16),
        .rs_idx    (rs_idx),
        .rt_idx    (rt_idx),
        .rd_idx    (rd_idx),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .flush     (flush),
        .out_ready (out_ready),
`ifdef ALU_ISSUE_FWD_EN
        .fwd_valid (fwd_valid),
        .fwd_idx   (fwd_idx),
        .fwd_data  (fwd_data),
`endif
        .out_valid (out_valid),
        .a         (a),
        .b         (b),
        .csig      (csig),
        .wdest     (wdest),
        .wen       (wen),
        .illegal   (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                             input logic [15:0] im, input logic [4:0] rsi, input logic [4:0] rti,
                             input logic [4:0] rdi, input logic [31:0] rsd, input logic [31:0] rtd);
        opcode  = op;
        funct   = fn;
        shamt   = sh;
        imm16   = im;
        rs_idx  = rsi;
        rt_idx  = rti;
        rd_idx  = rdi;
        rs_data = rsd;
        rt_data = rtd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({out_valid, csig, in_ready, a, b, wdest, wen, illegal} !==
            {1'b0, 4'b1011, 1'b1, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset got v=%b csig=%b rdy=%b a=%h b=%h wd=%0d wen=%b ill=%b required v=0 csig=1011 rdy=1 zeros",
                     out_valid, csig, in_ready, a, b, wdest, wen, illegal);
        end
        rst = 1'b0;
        $display("tx reset done");
    endtask

    task automatic test_decode();
        out_ready = 1'b1;
        // ADDI, negative immediate
        set_instr(6'h08, 6'h00, 5'd0, 16'hFFFE, 5'd1, 5'd7, 5'd9, 32'h5, 32'h77);
        in_valid = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL addi_latency got out_valid=%b required 0 before edge", out_valid);
        end
        tick();
        exp_snap = {1'b1, 32'h5, 32'hFFFF_FFFE, 4'b0110, 5'd7, 1'b1, 1'b0};
        checks++;
        if (snap !== exp_snap) begin
            errors++;
            $display("FAIL addi got %h required %h", snap, exp_snap);
        end
        $display("tx addi a=%h b=%h csig=%b", a, b, csig);

        // SLL rt=1, shamt=4
        set_instr(6'h00, 6'h00, 5'd4, 16'h0000, 5'd2, 5'd3, 5'd9, 32'hAAAA, 32'h1);
        tick();
        exp_snap = {1'b1, 32'h1, 32'h4, 4'b0011, 5'd9, 1'b1, 1'b0};
        checks++;
        if (snap !== exp_snap) begin
            errors++;
            $display("FAIL sll got %h required %h", snap, exp_snap);
        end
        $display("tx sll a=%h b=%h csig=%b", a, b, csig);

        // Unknown opcode 0x3F (rt and rd equal so wdest is unambiguous)
        set_instr(6'h3F, 6'h20, 5'd0, 16'h1234, 5'd2, 5'd9, 5'd9, 32'h5, 32'h6);
        tick();
        exp_snap = {1'b1, 32'h0, 32'h0, 4'b1011, 5'd9, 1'b0, 1'b1};
        checks++;
        if (snap !== exp_snap) begin
            errors++;
            $display("FAIL illegal_op got %h required %h", snap, exp_snap);
        end
        $display("tx illegal csig=%b ill=%b", csig, illegal);

        // R-type ADD
        set_instr(6'h00, 6'h20, 5'd0, 16'h0000, 5'd1, 5'd2, 5'd12, 32'h100, 32'h23);
        tick();
        exp_snap = {1'b1, 32'h100, 32'h23, 4'b0110, 5'd12, 1'b1, 1'b0};
        checks++;
        if (snap !== exp_snap) begin
            errors++;
            $display("FAIL radd got %h required %h", snap, exp_snap);
        end

        // ANDI zero-extends
        set_instr(6'h0C, 6'h00, 5'd0, 16'h8001, 5'd1, 5'd3, 5'd12, 32'hF0F0, 32'h0);
        tick();
        exp_snap = {1'b1, 32'hF0F0, 32'h0000_8001, 4'b0001, 5'd3, 1'b1, 1'b0};
        checks++;
        if (snap !== exp_snap) begin
            errors++;
            $display("FAIL andi got %h required %h", snap, exp_snap);
        end

        // SW: LWSW, sign-extended, no write-back
        set_instr(6'h2B, 6'h00, 5'd0, 16'hFFFC, 5'd4, 5'd5, 5'd12, 32'h1000, 32'h9);
        tick();
        exp_snap = {1'b1, 32'h1000, 32'hFFFF_FFFC, 4'b1101, 5'd5, 1'b0, 1'b0};
        checks++;
        if (snap !== exp_snap) begin
            errors++;
            $display("FAIL sw got %h required %h", snap, exp_snap);
        end

        // SRA shamt=31, unknown R funct afterwards
        set_instr(6'h00, 6'h03, 5'd31, 16'h0000, 5'd4, 5'd5, 5'd6, 32'h1, 32'h8000_0000);
        tick();
        exp_snap = {1'b1, 32'h8000_0000, 32'd31, 4'b1110, 5'd6, 1'b1, 1'b0};
        checks++;
        if (snap !== exp_snap) begin
            errors++;
            $display("FAIL sra got %h required %h", snap, exp_snap);
        end

        set_instr(6'h00, 6'h3F, 5'd0, 16'h0000, 5'd4, 5'd6, 5'd6, 32'h1, 32'h2);
        tick();
        exp_snap = {1'b1, 32'h0, 32'h0, 4'b1011, 5'd6, 1'b0, 1'b1};
        checks++;
        if (snap !== exp_snap) begin
            errors++;
            $display("FAIL illegal_funct got %h required %h", snap, exp_snap);
        end

        in_valid = 1'b0;
        tick();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL drain got v=%b rdy=%b required v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_instr(6'h08, 6'h00, 5'd0, 16'h0001, 5'd1, 5'd2, 5'd0, 32'h11, 32'h0);
        tick();
        checks++;
        if ({out_valid, in_ready, a} !== {1'b1, 1'b1, 32'h11}) begin
            errors++;
            $display("FAIL b2b_i1 got v=%b rdy=%b a=%h required v=1 rdy=1 a=11", out_valid, in_ready, a);
        end
        set_instr(6'h08, 6'h00, 5'd0, 16'h0001, 5'd1, 5'd2, 5'd0, 32'h22, 32'h0);
        tick();
        checks++;
        if ({out_valid, in_ready, a} !== {1'b1, 1'b0, 32'h11}) begin
            errors++;
            $display("FAIL b2b_skid got v=%b rdy=%b a=%h required v=1 rdy=0 a=11", out_valid, in_ready, a);
        end
        set_instr(6'h08, 6'h00, 5'd0, 16'h0001, 5'd1, 5'd2, 5'd0, 32'h33, 32'h0);
        tick();
        checks++;
        if ({out_valid, in_ready, a, b} !== {1'b1, 1'b0, 32'h11, 32'h1}) begin
            errors++;
            $display("FAIL b2b_hold got v=%b rdy=%b a=%h b=%h required v=1 rdy=0 a=11 b=1", out_valid, in_ready, a, b);
        end
        out_ready = 1'b1;
        $display("tx b2b delivered a=%h", a);
        tick();
        checks++;
        if ({out_valid, in_ready, a} !== {1'b1, 1'b1, 32'h22}) begin
            errors++;
            $display("FAIL b2b_i2 got v=%b rdy=%b a=%h required v=1 rdy=1 a=22", out_valid, in_ready, a);
        end
        $display("tx b2b delivered a=%h", a);
        tick();
        checks++;
        if ({out_valid, a} !== {1'b1, 32'h33}) begin
            errors++;
            $display("FAIL b2b_i3 got v=%b a=%h required v=1 a=33", out_valid, a);
        end
        $display("tx b2b delivered a=%h", a);
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_empty got v=%b required 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_instr(6'h08, 6'h00, 5'd0, 16'h0000, 5'd1, 5'd2, 5'd0, 32'h51, 32'h0);
        tick();
        set_instr(6'h08, 6'h00, 5'd0, 16'h0000, 5'd1, 5'd2, 5'd0, 32'h52, 32'h0);
        tick();
        checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            errors++;
            $display("FAIL flush_pre_skid got v=%b rdy=%b required v=1 rdy=0", out_valid, in_ready);
        end
        // Flush in SKID with an entry offered
        set_instr(6'h08, 6'h00, 5'd0, 16'h0000, 5'd1, 5'd2, 5'd0, 32'h53, 32'h0);
        flush = 1'b1;
        tick();
        checks++;
        if ({out_valid, in_ready, illegal} !== 3'b010) begin
            errors++;
            $display("FAIL flush_skid got v=%b rdy=%b ill=%b required v=0 rdy=1 ill=0", out_valid, in_ready, illegal);
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_replay got v=%b a=%h required v=0", out_valid, a);
        end

        // Flush in FULL holding an illegal entry, with a simultaneous accept
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_instr(6'h3F, 6'h00, 5'd0, 16'h0000, 5'd1, 5'd2, 5'd2, 32'h54, 32'h0);
        tick();
        checks++;
        if ({out_valid, illegal} !== 2'b11) begin
            errors++;
            $display("FAIL flush_pre_ill got v=%b ill=%b required v=1 ill=1", out_valid, illegal);
        end
        set_instr(6'h08, 6'h00, 5'd0, 16'h0000, 5'd1, 5'd2, 5'd0, 32'h55, 32'h0);
        flush = 1'b1;
        tick();
        checks++;
        if ({out_valid, illegal, in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL flush_full got v=%b ill=%b rdy=%b required v=0 ill=0 rdy=1", out_valid, illegal, in_ready);
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop got v=%b a=%h required v=0", out_valid, a);
        end
        // Stage still works after flush
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_instr(6'h08, 6'h00, 5'd0, 16'h0000, 5'd1, 5'd2, 5'd0, 32'h66, 32'h0);
        tick();
        checks++;
        if ({out_valid, a} !== {1'b1, 32'h66}) begin
            errors++;
            $display("FAIL flush_resume got v=%b a=%h required v=1 a=66", out_valid, a);
        end
        $display("tx post-flush a=%h", a);
        in_valid = 1'b0;
        tick();
    endtask

`ifdef ALU_ISSUE_FWD_EN
    task automatic test_forward();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        fwd_valid = 1'b1;
        fwd_idx   = 5'd3;
        fwd_data  = 32'hDEAD_BEEF;
        set_instr(6'h08, 6'h00, 5'd0, 16'h0000, 5'd3, 5'd4, 5'd0, 32'h0, 32'h0);
        tick();
        checks++;
        if (a !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL fwd_rs got a=%h required deadbeef", a);
        end
        fwd_idx = 5'd0;
        set_instr(6'h08, 6'h00, 5'd0, 16'h0000, 5'd0, 5'd4, 5'd0, 32'h1234, 32'h0);
        tick();
        checks++;
        if (a !== 32'h1234) begin
            errors++;
            $display("FAIL fwd_r0 got a=%h required 1234", a);
        end
        fwd_idx = 5'd4;
        set_instr(6'h00, 6'h20, 5'd0, 16'h0000, 5'd3, 5'd4, 5'd5, 32'h7, 32'h8);
        tick();
        checks++;
        if ({a, b} !== {32'h7, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL fwd_rt got a=%h b=%h required a=7 b=deadbeef", a, b);
        end
        fwd_valid = 1'b0;
        in_valid  = 1'b0;
        tick();
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
`ifdef ALU_ISSUE_FWD_EN
        fwd_valid = 1'b0;
        fwd_idx   = '0;
        fwd_data  = '0;
`endif
        set_instr(6'h00, 6'h00, 5'd0, 16'h0000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
        test_reset();
        test_decode();
        test_back_to_back();
        test_flush();
`ifdef ALU_ISSUE_FWD_EN
        test_forward();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage directly upstream of the ALU.
- Accepts decoded MIPS instruction fields plus register-file read data over a valid/ready handshake.
- Produces the ALU's operand pair a/b and the 4-bit csig operation code as registered outputs.
- Contains a 2-entry skid buffer so back-pressure from the hazard/stall logic never drops an instruction.

Parameters:
- DW, 32, operand/data width.
- RW, 5, register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept this cycle.
- opcode  in  6  instruction [31:26].
- funct  in  6  instruction [5:0].
- shamt  in  5  instruction [10:6].
- imm16  in  16  instruction [15:0].
- rs_idx, rt_idx, rd_idx  in  RW each  source and destination indices.
- rs_data, rt_data  in  DW each  register-file read data.
- flush  in  1  squash all held entries.
- out_ready  in  1  downstream/hazard unit accepts.
- out_valid  out  1  a/b/csig valid.
- a, b  out  DW each  ALU operands.
- csig  out  4  ALU op code.
- wdest  out  RW  write-back register (rd for R-type, rt for I-type).
- wen  out  1  result is written back.
- illegal  out  1  unrecognised opcode/funct.
- Forwarding ports (only with ALU_ISSUE_FWD_EN): fwd_valid in 1, fwd_idx in RW, fwd_data in DW.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: out_valid=0, a=b=0, csig=4'b1011 (CLR), wdest=0, wen=0, illegal=0, in_ready=1, state=EMPTY.
- csig encoding (shared with the ALU): OR 0000, AND 0001, XOR 0010, SLL 0011, SRL 0100, SUB 0101, ADD 0110, NOR 0111, NAND 1000, SLT 1001, MUL 1010, CLR 1011, STF 1100, LWSW 1101, SRA 1110, ANDN 1111.
- R-type decode (opcode 0x00), funct -> csig:
  - 0x25 OR, 0x24 AND, 0x26 XOR, 0x27 NOR, 0x22 SUB, 0x20 ADD, 0x2A SLT, 0x18 MUL: a=rs, b=rt.
  - 0x00 SLL, 0x02 SRL, 0x03 SRA: a=rt, b=zero-extended shamt.
  - wdest=rd, wen=1.
- I-type decode, a=rs, wdest=rt:
  - 0x08 ADDI -> ADD, sign-extended imm, wen=1.
  - 0x0A SLTI -> SLT, sign-extended imm, wen=1.
  - 0x0C ANDI / 0x0D ORI / 0x0E XORI -> AND/OR/XOR, zero-extended imm, wen=1.
  - 0x23 LW -> LWSW, sign-extended imm, wen=1.
  - 0x2B SW -> LWSW, sign-extended imm, wen=0.
- Illegal: any other opcode/funct gives csig=CLR, wen=0, illegal=1, a=b=0. The entry still flows through; it is not dropped.
- Decode is combinational on the input fields. The decoded entry is captured on accept (in_valid && in_ready).
- States:
  - EMPTY: nothing held.
  - FULL: output register valid.
  - SKID: output register plus skid register valid.
- in_ready = (state!=SKID), registered.
- Transitions:
  - EMPTY + accept -> FULL.
  - FULL + accept + !out_ready -> SKID; new entry goes to the skid register.
  - FULL + accept + out_ready -> FULL; output register reloads with the new entry.
  - FULL + !accept + out_ready -> EMPTY.
  - SKID + out_ready -> FULL; skid moves to output. No accept is possible in SKID.
- Latency: 1 cycle from accept to out_valid when not stalled.
- Order is strictly preserved. Outputs hold stable while out_valid && !out_ready.
- flush: next state EMPTY, out_valid=0, illegal=0. It overrides a simultaneous accept (the entry is dropped) and a simultaneous out_ready.
- rst mid-operation is equivalent to flush plus register clear.
- Arithmetic: sign extension replicates imm16[15] to DW. No arithmetic is performed here.

Optional Feature:
- Macro ALU_ISSUE_FWD_EN.
- Defined: on accept, if fwd_valid and fwd_idx==rs_idx and fwd_idx!=0, fwd_data replaces rs_data. The same rule applies independently for rt.
- Register 0 is never forwarded.
- Undefined: fwd_* ports are absent and rs_data/rt_data are used directly.

Decomposition:
- Package alu_pkg holds: the csig localparams/enum alu_op_e (all 16 codes above), opcode/funct constants, and the state enum issue_state_e {EMPTY, FULL, SKID}.
- One sub-module, alu_op_decode: combinational opcode/funct/imm -> {csig, b_sel, imm_ext, wdest_sel, wen, illegal}.

Test Plan:
- Reset: rst=1 for 2 cycles -> out_valid=0, csig=1011, in_ready=1.
- Decode: ADDI rs=0x0000_0005, imm=0xFFFE -> a=5, b=0xFFFF_FFFE, csig=0110, wdest=rt, wen=1, out_valid one cycle after accept.
- SLL with shamt=4 and rt=0x1 -> a=0x1, b=4, csig=0011. Unknown opcode 0x3F -> illegal=1, csig=1011, wen=0.
- Back-pressure: three back-to-back ADDs (I1..I3) with out_ready=0 for 2 cycles -> state SKID and in_ready=0 while I1 is held at the output. Releasing out_ready delivers I1, I2, I3 in order with none lost.
- Flush and accept in the same cycle while in SKID -> next cycle out_valid=0, in_ready=1, the flushed entries are never presented, and the entry offered in the flush cycle is dropped.
- With ALU_ISSUE_FWD_EN: fwd_valid=1, fwd_idx=rs_idx=3, fwd_data=0xDEAD_BEEF, rs_data=0 -> a=0xDEAD_BEEF. Repeating with fwd_idx=rs_idx=0 -> a=rs_data.
